// File: rtl/wb_stage.sv
// Writeback stage: registers the result of each retiring RV32I instruction, waits for load data,
// and flags misaligned or timed-out loads. Define WB_FWD_EN to add decode-stage bypass outputs.
module wb_stage #(
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_pc,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [31:0] instruction3,
    output logic [31:0] wdata,
    output logic        reg_wr,
    output logic        load_err
`ifdef WB_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data
`endif
);

    typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [7:0] CntLast  = 8'(LOAD_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        reg_wr_q, reg_wr_d;
    logic        load_err_q, load_err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;

    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_off;
    logic        ex_writer;
    logic        ex_jump;
    logic        ex_misaligned;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;
    logic [31:0] load_data;

    assign ex_opcode = ex_instr[6:0];
    assign ex_funct3 = ex_instr[14:12];
    assign ex_off    = ex_alu_result[1:0];
    assign ex_jump   = (ex_opcode == OpJal) || (ex_opcode == OpJalr);

    always_comb begin
        ex_writer = 1'b0;
        case (ex_opcode)
            OpLoad, OpOpImm, OpOp, OpLui, OpAuipc, OpJal, OpJalr: ex_writer = 1'b1;
            default:                                              ex_writer = 1'b0;
        endcase
    end

    // funct3 3, 6 and 7 are not defined loads and share the misalignment error path.
    always_comb begin
        ex_misaligned = 1'b1;
        case (ex_funct3)
            3'b000, 3'b100: ex_misaligned = 1'b0;
            3'b001, 3'b101: ex_misaligned = ex_off[0];
            3'b010:         ex_misaligned = (ex_off != 2'b00);
            default:        ex_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        rsp_byte = mem_rsp_data[7:0];
        case (off_q)
            2'd0:    rsp_byte = mem_rsp_data[7:0];
            2'd1:    rsp_byte = mem_rsp_data[15:8];
            2'd2:    rsp_byte = mem_rsp_data[23:16];
            default: rsp_byte = mem_rsp_data[31:24];
        endcase
        rsp_half  = off_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        load_data = mem_rsp_data;
        case (instr_q[14:12])
            3'b000:  load_data = {{24{rsp_byte[7]}}, rsp_byte};
            3'b001:  load_data = {{16{rsp_half[15]}}, rsp_half};
            3'b100:  load_data = {24'h0, rsp_byte};
            3'b101:  load_data = {16'h0, rsp_half};
            default: load_data = mem_rsp_data;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        wdata_d    = wdata_q;
        reg_wr_d   = 1'b0;
        load_err_d = 1'b0;
        cnt_d      = cnt_q;
        off_d      = off_q;
        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    instr_d = ex_instr;
                    if (ex_opcode == OpLoad) begin
                        if (ex_misaligned) begin
                            load_err_d = 1'b1;
                        end else begin
                            state_d = StLoadWait;
                            off_d   = ex_off;
                            cnt_d   = 8'd0;
                        end
                    end else begin
                        wdata_d  = ex_jump ? (ex_pc + 32'd4) : ex_alu_result;
                        reg_wr_d = ex_writer && (ex_instr[11:7] != 5'd0);
                    end
                end
            end
            StLoadWait: begin
                // A response arriving in the final timeout cycle still wins.
                if (mem_rsp_valid) begin
                    wdata_d  = load_data;
                    reg_wr_d = (instr_q[11:7] != 5'd0);
                    state_d  = StIdle;
                end else if (cnt_q == CntLast) begin
                    load_err_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            instr_q    <= 32'h0;
            wdata_q    <= 32'h0;
            reg_wr_q   <= 1'b0;
            load_err_q <= 1'b0;
            cnt_q      <= 8'd0;
            off_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            wdata_q    <= wdata_d;
            reg_wr_q   <= reg_wr_d;
            load_err_q <= load_err_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
        end
    end

    assign ex_ready     = (state_q == StIdle);
    assign instruction3 = instr_q;
    assign wdata        = wdata_q;
    assign reg_wr       = reg_wr_q;
    assign load_err     = load_err_q;

`ifdef WB_FWD_EN
    assign fwd_valid = reg_wr_q;
    assign fwd_rd    = instr_q[11:7];
    assign fwd_data  = wdata_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage, built with LOAD_TIMEOUT=4.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_pc;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [31:0] instruction3;
    logic [31:0] wdata;
    logic        reg_wr;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    wb_stage #(.LOAD_TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_instr      (ex_instr),
        .ex_alu_result (ex_alu_result),
        .ex_pc         (ex_pc),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .instruction3  (instruction3),
        .wdata         (wdata),
        .reg_wr        (reg_wr),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    // Advance one posedge and settle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] load_instr(input logic [2:0] f3, input logic [4:0] rd);
        return {12'h0, 5'd1, f3, rd, 7'b0000011};
    endfunction

    task automatic test_reset();
        reset = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; ex_pc = 32'h0;
        // A valid ADDI during reset must be overridden.
        ex_valid = 1'b1; ex_instr = {12'h0, 5'd0, 3'd0, 5'd5, 7'b0010011};
        ex_alu_result = 32'h1234;
        step();
        step();
        ex_valid = 1'b0; reset = 1'b0;
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL reset_reg_wr got %b exp 0", reg_wr); end
        checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wdata); end
        checks++; if (instruction3 !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instruction3); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b exp 0", load_err); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready); end
    endtask

    task automatic test_addi();
        ex_valid = 1'b1; ex_instr = {12'h0, 5'd0, 3'd0, 5'd5, 7'b0010011};
        ex_alu_result = 32'h0000_1234;
        step();
        ex_valid = 1'b0;
        checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL addi_reg_wr got %b exp 1", reg_wr); end
        checks++; if (instruction3[11:7] !== 5'd5) begin errors++; $display("FAIL addi_rd got %0d exp 5", instruction3[11:7]); end
        checks++; if (wdata !== 32'h0000_1234) begin errors++; $display("FAIL addi_wdata got %h exp 00001234", wdata); end
        step();
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL addi_reg_wr_drop got %b exp 0", reg_wr); end
    endtask

    task automatic test_jal();
        ex_valid = 1'b1; ex_instr = {20'h0, 5'd1, 7'b1101111};
        ex_pc = 32'hFFFF_FFFC; ex_alu_result = 32'hDEAD_BEEF;
        step();
        ex_valid = 1'b0;
        checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL jal_wdata got %h exp 00000000", wdata); end
        checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL jal_reg_wr got %b exp 1", reg_wr); end
    endtask

    task automatic test_non_writers();
        // ADD x0: instruction updates, no write.
        ex_valid = 1'b1; ex_instr = {7'h0, 5'd2, 5'd1, 3'd0, 5'd0, 7'b0110011};
        ex_alu_result = 32'h55;
        step();
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL add_x0_reg_wr got %b exp 0", reg_wr); end
        checks++; if (instruction3 !== 32'h0020_8033) begin errors++; $display("FAIL add_x0_instr got %h exp 00208033", instruction3); end
        // STORE with bits [11:7]=3 must not write.
        ex_instr = {7'h0, 5'd2, 5'd1, 3'd2, 5'd3, 7'b0100011};
        step();
        ex_valid = 1'b0;
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL store_reg_wr got %b exp 0", reg_wr); end
    endtask

    task automatic test_back_to_back();
        ex_valid = 1'b1; ex_instr = {12'h0, 5'd0, 3'd0, 5'd5, 7'b0010011}; ex_alu_result = 32'hA;
        step();
        ex_instr = {20'hABCDE, 5'd6, 7'b0110111}; ex_alu_result = 32'hABCD_E000;
        checks++; if (wdata !== 32'hA || reg_wr !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp 0000000a/1", wdata, reg_wr); end
        step();
        ex_valid = 1'b0;
        checks++; if (wdata !== 32'hABCD_E000 || reg_wr !== 1'b1 || instruction3[11:7] !== 5'd6) begin
            errors++; $display("FAIL b2b_second got %h/%b rd %0d exp abcde000/1 rd 6", wdata, reg_wr, instruction3[11:7]);
        end
    endtask

    task automatic test_load_byte();
        logic [3:0] busy_cycles;
        busy_cycles = 4'd0;
        ex_valid = 1'b1; ex_instr = load_instr(3'b000, 5'd7); ex_alu_result = 32'h0000_0102;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ex_ready === 1'b0 && reg_wr === 1'b0) busy_cycles++;
            if (i == 3) begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0080_0000; end
            step();
        end
        mem_rsp_valid = 1'b0;
        checks++; if (busy_cycles !== 4'd4) begin errors++; $display("FAIL lb_busy got %0d exp 4", busy_cycles); end
        checks++; if (wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wdata got %h exp ffffff80", wdata); end
        checks++; if (reg_wr !== 1'b1 || ex_ready !== 1'b1) begin errors++; $display("FAIL lb_done got wr %b rdy %b exp 1 1", reg_wr, ex_ready); end
        step();
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL lb_drop got %b exp 0", reg_wr); end
    endtask

    task automatic test_load_half_unsigned();
        ex_valid = 1'b1; ex_instr = load_instr(3'b101, 5'd9); ex_alu_result = 32'h0000_0202;
        step();
        ex_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h8001_7FFF;
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (wdata !== 32'h0000_8001 || reg_wr !== 1'b1) begin errors++; $display("FAIL lhu_result got %h/%b exp 00008001/1", wdata, reg_wr); end
        // LH at offset 0 sign-extends the low half.
        ex_valid = 1'b1; ex_instr = load_instr(3'b001, 5'd9); ex_alu_result = 32'h0000_0200;
        step();
        ex_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_9ABC;
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (wdata !== 32'hFFFF_9ABC) begin errors++; $display("FAIL lh_result got %h exp ffff9abc", wdata); end
    endtask

    task automatic test_misaligned();
        logic [2:0] f3s [4];
        logic [1:0] offs [4];
        f3s[0] = 3'b010; offs[0] = 2'd2;
        f3s[1] = 3'b001; offs[1] = 2'd1;
        f3s[2] = 3'b101; offs[2] = 2'd3;
        f3s[3] = 3'b011; offs[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; ex_instr = load_instr(f3s[i], 5'd4);
            ex_alu_result = {28'h0000100, 2'b00, offs[i]};
            step();
            ex_valid = 1'b0;
            checks++; if (load_err !== 1'b1 || reg_wr !== 1'b0 || ex_ready !== 1'b1) begin
                errors++; $display("FAIL misalign_%0d got err %b wr %b rdy %b exp 1 0 1", i, load_err, reg_wr, ex_ready);
            end
            step();
            checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL misalign_pulse_%0d got %b exp 0", i, load_err); end
        end
    endtask

    task automatic test_timeout();
        logic       early_err;
        early_err = 1'b0;
        ex_valid = 1'b1; ex_instr = load_instr(3'b010, 5'd6); ex_alu_result = 32'h100;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (load_err !== 1'b0 || ex_ready !== 1'b0) early_err = 1'b1;
            step();
        end
        checks++; if (early_err !== 1'b0) begin errors++; $display("FAIL timeout_wait got early %b exp 0", early_err); end
        checks++; if (load_err !== 1'b1 || reg_wr !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_err got err %b wr %b rdy %b exp 1 0 1", load_err, reg_wr, ex_ready);
        end
        step();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b exp 0", load_err); end
        // Response on the last wait cycle beats the timeout.
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678; end
            step();
        end
        mem_rsp_valid = 1'b0;
        checks++; if (load_err !== 1'b0 || reg_wr !== 1'b1 || wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL timeout_race got err %b wr %b data %h exp 0 1 12345678", load_err, reg_wr, wdata);
        end
        // A response while idle is ignored.
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (reg_wr !== 1'b0 || wdata !== 32'h1234_5678) begin errors++; $display("FAIL idle_rsp got wr %b data %h exp 0 12345678", reg_wr, wdata); end
    endtask

    task automatic test_reset_mid_load();
        ex_valid = 1'b1; ex_instr = load_instr(3'b010, 5'd6); ex_alu_result = 32'h200;
        step();
        ex_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        step();
        mem_rsp_valid = 1'b0;
        checks++; if (reg_wr !== 1'b0 || load_err !== 1'b0 || wdata !== 32'h0 || instruction3 !== 32'h0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_load got wr %b err %b data %h instr %h rdy %b exp 0 0 0 0 1",
                               reg_wr, load_err, wdata, instruction3, ex_ready);
        end
    endtask

    initial begin
        ex_valid = 1'b0; ex_instr = 32'h0; ex_alu_result = 32'h0; ex_pc = 32'h0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; reset = 1'b1;
        #1;
        test_reset();
        test_addi();
        test_jal();
        test_non_writers();
        test_back_to_back();
        test_load_byte();
        test_load_half_unsigned();
        test_misaligned();
        test_timeout();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter LOAD_TIMEOUT, default 15, meaning the number of cycles to wait in LOAD_WAIT before aborting a load (legal range 1..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ex_valid  input  1  execute stage presents an instruction.
REQ-005 SHALL have port ex_ready  output  1  wb_stage accepts the instruction this cycle.
REQ-006 SHALL have port ex_instr  input  32  RV32I instruction word from execute.
REQ-007 SHALL have port ex_alu_result  input  32  ALU result or load/store effective address.
REQ-008 SHALL have port ex_pc  input  32  PC of ex_instr.
REQ-009 SHALL have port mem_rsp_valid  input  1  data memory load response valid.
REQ-010 SHALL have port mem_rsp_data  input  32  word-aligned load response word.
REQ-011 SHALL have port instruction3  output  32  registered writeback instruction; rd is taken from [11:7] by the register file.
REQ-012 SHALL have port wdata  output  32  registered writeback data.
REQ-013 SHALL have port reg_wr  output  1  registered register-file write enable.
REQ-014 SHALL have port load_err  output  1  one-cycle pulse on load timeout or misalignment.

Function
REQ-015 SHALL implement FSM states IDLE and LOAD_WAIT.
- ex_ready = 1 in IDLE, 0 in LOAD_WAIT.
- Handshake: transfer when ex_valid & ex_ready.
REQ-016 SHALL treat these opcodes as writers: LOAD 0000011, OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- All other opcodes, including STORE and BRANCH, SHALL give reg_wr=0.
REQ-017 SHALL, for a non-load transfer in IDLE, drive instruction3, wdata and reg_wr on the next posedge and hold them for exactly one cycle (latency 1).
- Write data: JAL/JALR give wdata=ex_pc+4 (mod 2^32); others give wdata=ex_alu_result.
REQ-018 SHALL force reg_wr=0 whenever rd==0; instruction3 still updates.
REQ-019 SHALL, for a LOAD transfer, latch the instruction and address offset ex_alu_result[1:0], enter LOAD_WAIT and deassert reg_wr the next cycle.
REQ-020 SHALL, in LOAD_WAIT with mem_rsp_valid=1, extract the response per funct3 using the latched offset and return to IDLE.
- Result registered: reg_wr=1 and wdata valid on the next cycle (1 cycle after the response).
- LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
REQ-021 SHALL treat a load as misaligned when it is LH/LHU at offset 1 or 3, or LW at offset ≠0.
- On misalignment: no memory wait, load_err pulses the next cycle, reg_wr=0, remain in IDLE.
REQ-022 SHALL handle load timeout as follows.
- A timeout counter starts at 0 on entry to LOAD_WAIT.
- If LOAD_TIMEOUT cycles elapse without a response: pulse load_err, reg_wr=0, return to IDLE.
REQ-023 SHALL give the response priority when mem_rsp_valid arrives in the same cycle the timeout expires: normal write, no load_err.
REQ-024 SHALL ignore mem_rsp_valid in IDLE.
REQ-025 SHALL treat funct3 values 3, 6 and 7 on LOAD as misaligned/illegal, with the same error behaviour as REQ-021.
REQ-026 SHALL keep all outputs except ex_ready registered, stable from posedge to posedge, so the register file can sample them on negedge.

Reset
REQ-027 SHALL, on reset, clear all state at the next posedge.
- State=IDLE, instruction3=0, wdata=0, reg_wr=0, load_err=0, timeout counter=0.
REQ-028 SHALL let reset asserted mid-load abandon the load: no write, no load_err.
- A later mem_rsp_valid is ignored per REQ-024.
REQ-029 SHALL let reset override all other inputs in the same cycle.

Configuration
REQ-030 SHALL provide macro WB_FWD_EN.
- When defined: outputs fwd_valid (1), fwd_rd (5) and fwd_data (32) are added.
- fwd_valid equals reg_wr, fwd_rd equals instruction3[11:7], fwd_data equals wdata; these are used for decode-stage bypass.
- When undefined: these ports and their logic are absent and all other behaviour is identical.

Verification
REQ-031 SHALL cover ADDI x5, result 0x0000_1234 -> next cycle reg_wr=1, instruction3[11:7]=5, wdata=0x0000_1234, then reg_wr=0.
REQ-032 SHALL cover JAL x1 at ex_pc=0xFFFF_FFFC -> wdata=0x0000_0000, reg_wr=1.
REQ-033 SHALL cover LB x7, offset 2, response 0x0080_0000 after 3 cycles -> ex_ready=0 for 4 cycles; wdata=0xFFFF_FF80, reg_wr=1 one cycle after the response.
REQ-034 SHALL cover LW at address 0x...02 -> load_err pulses one cycle, reg_wr=0, ex_ready stays 1.
REQ-035 SHALL cover a load with no response and LOAD_TIMEOUT=4 -> load_err after 4 cycles in LOAD_WAIT, return to IDLE; a response on the 4th cycle instead gives a write with no load_err.
REQ-036 SHALL cover ADD x0 -> reg_wr=0; reset during LOAD_WAIT followed by a response -> no write, outputs all 0.
